pico_io_unit: RTL and testbench



---
 rtl/pico_io_pkg.sv | 21 ++
 rtl/io_fifo.sv | 63 ++++++
 rtl/pico_io_unit.sv | 115 +++++++++++
 tb/tb_pico_io_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pico_io_pkg.sv
// Shared types and width helpers for the picoMIPS multi-channel I/O unit.
package pico_io_pkg;

    function automatic int unsigned ch_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DefaultChannels = 4;
    localparam int unsigned CH_W = ch_width(DefaultChannels);

    typedef logic [CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/io_fifo.sv
// Single-clock input FIFO; a pop frees a slot for a push in the same cycle.
module io_fifo
    import pico_io_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned FifoDepth = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [N-1:0] head
);

    localparam int unsigned PtrW = ptr_width(FifoDepth);
    localparam int unsigned CntW = cnt_width(FifoDepth);

    logic [N-1:0]    mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CntW'(FifoDepth));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pico_io_unit.sv
// Buffered multi-channel I/O unit: input FIFOs, output holding registers, LD/ST stall logic.
// Optional PICO_IO_EDGE_DETECT_EN makes input strobes push once per rising edge.
module pico_io_unit
    import pico_io_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned Channels  = 4,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [Channels*N-1:0]        in_bus,
    input  logic [Channels-1:0]          in_strobe,
    input  logic [Channels-1:0]          out_ack,
    input  logic                         rd_req,
    input  logic [ch_width(Channels)-1:0] rd_ch,
    input  logic                         wr_req,
    input  logic [ch_width(Channels)-1:0] wr_ch,
    input  logic [N-1:0]                 cpu_out,
    output logic [N-1:0]                 cpu_in,
    output logic [Channels*N-1:0]        out_bus,
    output logic [Channels-1:0]          out_valid,
    output logic [Channels-1:0]          overflow,
    output logic                         halt_program
);

    localparam int unsigned ChW = ch_width(Channels);

    logic [Channels-1:0]   push, pop, full, empty;
    logic [N-1:0]          head [Channels];
    logic [Channels*N-1:0] out_bus_q, out_bus_d;
    logic [Channels-1:0]   out_valid_q, out_valid_d;
    logic [Channels-1:0]   overflow_q, overflow_d;
    logic                  rd_empty, wr_busy;

`ifdef PICO_IO_EDGE_DETECT_EN
    logic [Channels-1:0] strobe_q;

    always_ff @(posedge clk) begin
        if (reset) strobe_q <= '0;
        else       strobe_q <= in_strobe;
    end

    assign push = in_strobe & ~strobe_q;
`else
    assign push = in_strobe;
`endif

    for (genvar c = 0; c < Channels; c++) begin : g_fifo
        assign pop[c] = rd_req && (rd_ch == ChW'(c));

        io_fifo #(
            .N         (N),
            .FifoDepth (FifoDepth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdata (in_bus[c*N +: N]),
            .full  (full[c]),
            .empty (empty[c]),
            .head  (head[c])
        );
    end

    // Out-of-range channel indices fall through as empty/occupied so the CPU stalls.
    always_comb begin
        rd_empty = 1'b1;
        wr_busy  = 1'b1;
        cpu_in   = '0;
        for (int c = 0; c < Channels; c++) begin
            if (rd_ch == ChW'(c)) begin
                rd_empty = empty[c];
                cpu_in   = empty[c] ? '0 : head[c];
            end
            if (wr_ch == ChW'(c)) wr_busy = out_valid_q[c];
        end
    end

    assign halt_program = (rd_req & rd_empty) | (wr_req & wr_busy);

    always_comb begin
        out_bus_d   = out_bus_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        for (int c = 0; c < Channels; c++) begin
            if (wr_req && (wr_ch == ChW'(c)) && !out_valid_q[c]) begin
                out_bus_d[c*N +: N] = cpu_out;
                out_valid_d[c]      = 1'b1;
            end else if (out_ack[c]) begin
                out_valid_d[c] = 1'b0;
            end
            // A full FIFO only accepts a push when it is popped in the same cycle.
            if (push[c] && full[c] && !pop[c]) overflow_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_bus_q   <= '0;
            out_valid_q <= '0;
            overflow_q  <= '0;
        end else begin
            out_bus_q   <= out_bus_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_bus   = out_bus_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pico_io_unit.sv
// Directed self-checking bench for pico_io_unit (N=8, Channels=4, FifoDepth=4).
module tb_pico_io_unit;

    localparam int unsigned N         = 8;
    localparam int unsigned Channels  = 4;
    localparam int unsigned FifoDepth = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [Channels*N-1:0] in_bus;
    logic [Channels-1:0]   in_strobe;
    logic [Channels-1:0]   out_ack;
    logic                  rd_req;
    logic [1:0]            rd_ch;
    logic                  wr_req;
    logic [1:0]            wr_ch;
    logic [N-1:0]          cpu_out;
    logic [N-1:0]          cpu_in;
    logic [Channels*N-1:0] out_bus;
    logic [Channels-1:0]   out_valid;
    logic [Channels-1:0]   overflow;
    logic                  halt_program;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pico_io_unit #(
        .N         (N),
        .Channels  (Channels),
        .FifoDepth (FifoDepth)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_bus       (in_bus),
        .in_strobe    (in_strobe),
        .out_ack      (out_ack),
        .rd_req       (rd_req),
        .rd_ch        (rd_ch),
        .wr_req       (wr_req),
        .wr_ch        (wr_ch),
        .cpu_out      (cpu_out),
        .cpu_in       (cpu_in),
        .out_bus      (out_bus),
        .out_valid    (out_valid),
        .overflow     (overflow),
        .halt_program (halt_program)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_strobe = '0;
        out_ack   = '0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // One-cycle strobe followed by a low cycle, so both strobe modes push exactly once.
    task automatic push_val(input int ch, input logic [7:0] val);
        in_bus[ch*N +: N] = val;
        in_strobe[ch]     = 1'b1;
        tick();
        in_strobe[ch]     = 1'b0;
        tick();
    endtask

    task automatic ld_expect(input string tag, input logic [1:0] ch, input logic [7:0] val);
        rd_req = 1'b1;
        rd_ch  = ch;
        #1;
        check_eq({tag, "_halt"}, halt_program, 0);
        check_eq({tag, "_data"}, cpu_in, val);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic ld_halt(input string tag, input logic [1:0] ch);
        rd_req = 1'b1;
        rd_ch  = ch;
        #1;
        check_eq({tag, "_halt"}, halt_program, 1);
        check_eq({tag, "_data"}, cpu_in, 0);
        tick();
        rd_req = 1'b0;
    endtask

    initial begin
        in_bus  = '0;
        cpu_out = '0;
        rd_ch   = '0;
        wr_ch   = '0;
        do_reset();

        // Reset state
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_out_bus", out_bus, 0);
        check_eq("rst_cpu_in", cpu_in, 0);
        check_eq("rst_halt_idle", halt_program, 0);
        ld_halt("rst_ld_empty", 2'd2);

        // Single push and read on ch1, then FIFO is empty again
        push_val(1, 8'h5A);
        ld_expect("ch1_ld", 2'd1, 8'h5A);
        ld_halt("ch1_after", 2'd1);

        // Overflow on ch0, surviving data in order
        for (int i = 1; i <= 5; i++) push_val(0, 8'(i));
        check_eq("ovf_flag", overflow, 4'b0001);
        for (int i = 1; i <= 4; i++) ld_expect("ovf_ld", 2'd0, 8'(i));
        ld_halt("ovf_ld5", 2'd0);
        check_eq("ovf_sticky", overflow, 4'b0001);

        // Full + push + pop in one cycle, across pointer wrap
        do_reset();
        check_eq("rst2_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) push_val(2, 8'h10 + 8'(i));
        in_bus[2*N +: N] = 8'h14;
        in_strobe[2]     = 1'b1;
        rd_req           = 1'b1;
        rd_ch            = 2'd2;
        #1;
        check_eq("fpp_halt", halt_program, 0);
        check_eq("fpp_data", cpu_in, 8'h10);
        tick();
        in_strobe[2] = 1'b0;
        rd_req       = 1'b0;
        #1;
        check_eq("fpp_no_ovf", overflow, 0);
        for (int i = 1; i <= 4; i++) ld_expect("fpp_ld", 2'd2, 8'h10 + 8'(i));
        ld_halt("fpp_ld_end", 2'd2);

        // Store, stall on occupied, ack, retried store
        cpu_out = 8'hC3;
        wr_req  = 1'b1;
        wr_ch   = 2'd3;
        #1;
        check_eq("st1_halt", halt_program, 0);
        tick();
        check_eq("st1_valid", out_valid, 4'b1000);
        check_eq("st1_bus", out_bus[31:24], 8'hC3);
        cpu_out = 8'h3C;
        #1;
        check_eq("st2_halt_busy", halt_program, 1);
        tick();
        check_eq("st2_keep", out_bus[31:24], 8'hC3);
        out_ack[3] = 1'b1;
        #1;
        check_eq("st2_halt_ack", halt_program, 1);
        tick();
        out_ack[3] = 1'b0;
        #1;
        check_eq("ack_valid", out_valid, 4'b0000);
        check_eq("ack_bus_kept", out_bus[31:24], 8'hC3);
        check_eq("st2_halt_free", halt_program, 0);
        tick();
        wr_req = 1'b0;
        check_eq("st2_valid", out_valid, 4'b1000);
        check_eq("st2_bus", out_bus[31:24], 8'h3C);
        out_ack[0] = 1'b1;
        tick();
        out_ack[0] = 1'b0;
        check_eq("ack_idle_ignored", out_valid, 4'b1000);

        // Strobe held high for three cycles
        in_strobe[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_bus[1*N +: N] = 8'h77 + 8'(i);
            tick();
        end
        in_strobe[1] = 1'b0;
        tick();
        ld_expect("hold_ld0", 2'd1, 8'h77);
`ifdef PICO_IO_EDGE_DETECT_EN
        ld_halt("hold_end", 2'd1);
`else
        ld_expect("hold_ld1", 2'd1, 8'h78);
        ld_expect("hold_ld2", 2'd1, 8'h79);
        ld_halt("hold_end", 2'd1);
`endif

        // Reset mid-operation drops buffered input and pending output
        push_val(0, 8'hAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_bus", out_bus, 0);
        ld_halt("mid_rst_ld", 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
